dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit storage words; power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to ready; legal range 1..15.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dmem_addr  input  32  byte address of the request.
REQ-007 dmem_r_enable  input  1  read request.
REQ-008 dmem_w_enable  input  1  write request.
REQ-009 dmem_w_size  input  2  write size: 0 byte, 1 halfword, 2 word, 3 reserved.
REQ-010 dmem_w_data  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 dmem_r_data  output  32  aligned word containing the read address.
REQ-012 dmem_ready  output  1  one-cycle completion strobe for the accepted request.
REQ-013 dmem_err  output  1  error flag, valid only while dmem_ready is high.

Function
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE: if dmem_r_enable or dmem_w_enable is high at a clock edge, capture addr, w_data, w_size, request type; load counter with LATENCY-1; go BUSY if LATENCY>1, else DONE.
REQ-016 BUSY: decrement counter each cycle; enter DONE on the cycle after counter reaches 1; enable inputs ignored.
REQ-017 DONE: dmem_ready high for exactly this one cycle; next state IDLE unconditionally; enable inputs ignored.
REQ-018 Request-to-ready latency is exactly LATENCY cycles: ready high in cycle N+LATENCY when accepted at edge N.
REQ-019 Requester holds enables high until it samples ready; a still-high enable in the IDLE cycle after DONE is accepted as a new request.
REQ-020 Both enables high at acceptance: request is an error (REQ-023); no write, dmem_r_data = 0.
REQ-021 Read: in DONE, dmem_r_data = mem[(addr-BASE_ADDR)>>2], full word regardless of addr[1:0]; registered, stable only while ready high, 0 otherwise.
REQ-022 Write committed in the DONE cycle (visible to a read accepted afterwards): size 0 writes w_data[7:0] to byte lane addr[1:0]; size 1 writes w_data[15:0] to lanes {addr[1],0}..+1; size 2 writes whole word; other lanes unchanged.
REQ-023 dmem_err high with ready and no storage update, dmem_r_data = 0, when: both enables; w_size = 3 on write; halfword write with addr[0]=1; word write with addr[1:0]!=0; addr < BASE_ADDR; word index >= DEPTH.
REQ-024 Reads with nonzero addr[1:0] are not errors (requester extracts lanes).
REQ-025 Address offset arithmetic is 32-bit unsigned; wrap below BASE_ADDR detected as error, never aliased.

Reset
REQ-026 On reset assertion, immediately (asynchronously): state IDLE, counter 0, dmem_ready 0, dmem_err 0, dmem_r_data 0.
REQ-027 Reset mid-request (BUSY or DONE) discards the request; a pending write is not committed; no ready is issued for it.
REQ-028 Storage contents are not cleared by reset.
REQ-029 First request is accepted on the first rising edge after reset deasserts.

Verification
REQ-030 LATENCY=2: word write 0xDEADBEEF @0x10 -> ready 2 cycles after accept, err 0; then read @0x10 -> r_data 0xDEADBEEF with ready.
REQ-031 Byte write 0xAA @0x13 over 0x11223344 -> read @0x10 returns 0xAA223344; half write 0x5566 @0x12 -> 0x55663344.
REQ-032 Word write @0x12, half write @0x11, w_size 3, addr DEPTH*4 -> each gets ready with err 1, word unchanged.
REQ-033 Both enables high @0x0 -> ready, err 1, r_data 0, memory unchanged.
REQ-034 Write accepted, reset pulsed in BUSY -> no ready, outputs 0, read afterwards returns old contents.
REQ-035 Enables held high continuously, LATENCY=1 -> ready every second cycle (accept, DONE, accept, ...).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read or write request at a time,
// answers after a fixed LATENCY with a one-cycle ready strobe, and flags
// malformed or out-of-range requests with dmem_err instead of touching storage.
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_r_enable,
  input  logic        dmem_w_enable,
  input  logic [1:0]  dmem_w_size,
  input  logic [31:0] dmem_w_data,
  output logic [31:0] dmem_r_data,
  output logic        dmem_ready,
  output logic        dmem_err
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_wData;
  logic [1:0]  r_wSize;
  logic        r_isRead;
  logic        r_isWrite;
  logic [31:0] r_rData;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic [31:0] w_selAddr;
  logic [31:0] w_selWData;
  logic [1:0]  w_selSize;
  logic        w_selRead;
  logic        w_selWrite;
  logic [31:0] w_wordIdx;
  logic [IDX_W-1:0] w_idx;
  logic        w_err;
  logic [3:0]  w_laneEn;
  logic [31:0] w_laneData;

  assign w_accept = (r_state == IDLE) && (dmem_r_enable || dmem_w_enable);

  // In IDLE the request is still on the inputs (needed when LATENCY is 1 and
  // DONE follows acceptance directly); afterwards the captured copy is used.
  assign w_selAddr  = (r_state == IDLE) ? dmem_addr     : r_addr;
  assign w_selWData = (r_state == IDLE) ? dmem_w_data   : r_wData;
  assign w_selSize  = (r_state == IDLE) ? dmem_w_size   : r_wSize;
  assign w_selRead  = (r_state == IDLE) ? dmem_r_enable : r_isRead;
  assign w_selWrite = (r_state == IDLE) ? dmem_w_enable : r_isWrite;

  // Unsigned 32-bit offset; an address below the base wraps to a huge index,
  // but the explicit below-base test keeps it from ever aliasing.
  assign w_wordIdx = (w_selAddr - BASE_ADDR) >> 2;
  assign w_idx     = w_wordIdx[IDX_W-1:0];

  assign w_err = (w_selRead && w_selWrite)
               || (w_selWrite && (w_selSize == 2'd3))
               || (w_selWrite && (w_selSize == 2'd1) && w_selAddr[0])
               || (w_selWrite && (w_selSize == 2'd2) && (w_selAddr[1:0] != 2'b00))
               || (w_selAddr < BASE_ADDR)
               || (w_wordIdx >= DEPTH_W);

  // Byte-lane enables and lane-replicated write data for the write size
  always_comb begin
    w_laneEn   = 4'b0000;
    w_laneData = w_selWData;
    case (w_selSize)
      2'd0: begin
        w_laneEn   = 4'b0001 << w_selAddr[1:0];
        w_laneData = {4{w_selWData[7:0]}};
      end
      2'd1: begin
        w_laneEn   = w_selAddr[1] ? 4'b1100 : 4'b0011;
        w_laneData = {2{w_selWData[15:0]}};
      end
      2'd2: begin
        w_laneEn   = 4'b1111;
        w_laneData = w_selWData;
      end
      default: begin
        w_laneEn   = 4'b0000;
        w_laneData = w_selWData;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: BUSY lasts LATENCY-1 cycles, DONE exactly one
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (LATENCY > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (r_count <= 4'd1) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Capture the accepted request and run the latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 4'd0;
      r_addr    <= 32'd0;
      r_wData   <= 32'd0;
      r_wSize   <= 2'd0;
      r_isRead  <= 1'b0;
      r_isWrite <= 1'b0;
    end else if (w_accept) begin
      r_count   <= CNT_LOAD;
      r_addr    <= dmem_addr;
      r_wData   <= dmem_w_data;
      r_wSize   <= dmem_w_size;
      r_isRead  <= dmem_r_enable;
      r_isWrite <= dmem_w_enable;
    end else if (r_state == BUSY) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Response registers: loaded on entry to DONE, zero at all other times
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rData <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_nextState == DONE) begin
      r_err   <= w_err;
      r_rData <= (w_selRead && !w_err) ? r_mem[w_idx] : 32'd0;
    end else begin
      r_err   <= 1'b0;
      r_rData <= 32'd0;
    end
  end

  // Storage write commits at the end of DONE; reset drops the state out of
  // DONE immediately, so an interrupted write is never committed
  always_ff @(posedge clk) begin
    if ((r_state == DONE) && r_isWrite && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_laneEn[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_laneData[8*i +: 8];
        end
      end
    end
  end

  assign dmem_ready  = (r_state == DONE);
  assign dmem_err    = r_err;
  assign dmem_r_data = r_rData;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: instance A (LATENCY 2, base 0) and
// instance B (LATENCY 1, base 0x100) with a queue of expected responses.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] aAddr, bAddr;
  logic        aRen, bRen, aWen, bWen;
  logic [1:0]  aSize, bSize;
  logic [31:0] aWData, bWData;
  logic [31:0] aRData, bRData;
  logic        aReady, bReady, aErr, bErr;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        checkData;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] modelMem [2][256];

  dmem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) uA (
    .clk(clk), .reset(reset), .dmem_addr(aAddr), .dmem_r_enable(aRen),
    .dmem_w_enable(aWen), .dmem_w_size(aSize), .dmem_w_data(aWData),
    .dmem_r_data(aRData), .dmem_ready(aReady), .dmem_err(aErr)
  );

  dmem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_0100), .LATENCY(1)) uB (
    .clk(clk), .reset(reset), .dmem_addr(bAddr), .dmem_r_enable(bRen),
    .dmem_w_enable(bWen), .dmem_w_size(bSize), .dmem_w_data(bWData),
    .dmem_r_data(bRData), .dmem_ready(bReady), .dmem_err(bErr)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck bench still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one request on instance sel, queue the expected response, then wait
  // for ready and compare latency, error flag and (for reads/errors) data
  task automatic issue(input int sel, input logic [31:0] addr, input logic rd,
                       input logic wr, input logic [1:0] size,
                       input logic [31:0] data, input string name);
    logic [31:0] base;
    int          lat;
    logic        err;
    logic [31:0] idx;
    exp_t        e;
    exp_t        got;
    int          cycles;
    logic        rdy;
    logic [31:0] word;

    base = (sel == 1) ? 32'h100 : 32'h0;
    lat  = (sel == 1) ? 1 : 2;
    idx  = (addr - base) >> 2;
    err  = (rd && wr) || (wr && size == 2'd3) || (wr && size == 2'd1 && addr[0])
        || (wr && size == 2'd2 && addr[1:0] != 2'b00) || (addr < base) || (idx >= 32'd256);

    e.err       = err;
    e.checkData = rd || err;
    e.rdata     = (err || !rd) ? 32'd0 : modelMem[sel][idx[7:0]];
    e.name      = name;
    sbq.push_back(e);

    if (wr && !err) begin
      word = modelMem[sel][idx[7:0]];
      case (size)
        2'd0: word[8*addr[1:0] +: 8] = data[7:0];
        2'd1: word[16*addr[1] +: 16] = data[15:0];
        default: word = data;
      endcase
      modelMem[sel][idx[7:0]] = word;
    end

    @(negedge clk);
    if (sel == 1) begin
      bAddr = addr; bRen = rd; bWen = wr; bSize = size; bWData = data;
    end else begin
      aAddr = addr; aRen = rd; aWen = wr; aSize = size; aWData = data;
    end
    @(posedge clk);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      rdy = (sel == 1) ? bReady : aReady;
    end while (!rdy && cycles < 20);

    got = sbq.pop_front();
    checks++;
    if (!rdy) begin
      failures++;
      $display("[TB] FAIL %s timeout: got no ready in %0d cycles, required ready", name, cycles);
    end else if (cycles != lat) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d cycles, required %0d", name, cycles, lat);
    end

    checks++;
    if (((sel == 1) ? bErr : aErr) !== got.err) begin
      failures++;
      $display("[TB] FAIL %s err: got %b, required %b", name, (sel == 1) ? bErr : aErr, got.err);
    end
    if (got.checkData) begin
      checks++;
      if (((sel == 1) ? bRData : aRData) !== got.rdata) begin
        failures++;
        $display("[TB] FAIL %s rdata: got %h, required %h", name,
                 (sel == 1) ? bRData : aRData, got.rdata);
      end
    end

    aRen = 1'b0; aWen = 1'b0; bRen = 1'b0; bWen = 1'b0;
  endtask

  // Outputs are zero while reset is held; release lands on a falling edge
  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (aReady !== 1'b0 || bReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b/%b, required 0/0", aReady, bReady);
    end
    checks++;
    if (aErr !== 1'b0 || bErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err: got %b/%b, required 0/0", aErr, bErr);
    end
    checks++;
    if (aRData !== 32'd0 || bRData !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_rdata: got %h/%h, required 0/0", aRData, bRData);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Plain word write then read back
  task automatic test_word_write_read();
    issue(0, 32'h10, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF, "word_write");
    issue(0, 32'h10, 1'b1, 1'b0, 2'd0, 32'h0, "word_read");
    checks++;
    if (modelMem[0][4] !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL model_word: got %h, required deadbeef", modelMem[0][4]);
    end
  endtask

  // Byte and halfword merges into an existing word, unaligned read
  task automatic test_partial_writes();
    issue(0, 32'h10, 1'b0, 1'b1, 2'd2, 32'h11223344, "base_word");
    issue(0, 32'h13, 1'b0, 1'b1, 2'd0, 32'h000000AA, "byte_write");
    issue(0, 32'h10, 1'b1, 1'b0, 2'd0, 32'h0, "byte_read");
    checks++;
    if (modelMem[0][4] !== 32'hAA223344) begin
      failures++;
      $display("[TB] FAIL model_byte: got %h, required aa223344", modelMem[0][4]);
    end
    issue(0, 32'h10, 1'b0, 1'b1, 2'd2, 32'h11223344, "base_word2");
    issue(0, 32'h12, 1'b0, 1'b1, 2'd1, 32'h00005566, "half_write");
    issue(0, 32'h13, 1'b1, 1'b0, 2'd0, 32'h0, "half_read_unaligned");
    checks++;
    if (modelMem[0][4] !== 32'h55663344) begin
      failures++;
      $display("[TB] FAIL model_half: got %h, required 55663344", modelMem[0][4]);
    end
  endtask

  // Malformed and out-of-range writes leave the word untouched
  task automatic test_errors();
    issue(0, 32'h12, 1'b0, 1'b1, 2'd2, 32'hFFFFFFFF, "err_word_misaligned");
    issue(0, 32'h11, 1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, "err_half_misaligned");
    issue(0, 32'h10, 1'b0, 1'b1, 2'd3, 32'hFFFFFFFF, "err_size3");
    issue(0, 32'h400, 1'b0, 1'b1, 2'd2, 32'hFFFFFFFF, "err_depth_write");
    issue(0, 32'h400, 1'b1, 1'b0, 2'd0, 32'h0, "err_depth_read");
    issue(0, 32'h10, 1'b1, 1'b0, 2'd0, 32'h0, "err_unchanged");
  endtask

  // Both enables high is an error with no write
  task automatic test_both_enables();
    issue(0, 32'h0, 1'b0, 1'b1, 2'd2, 32'h0BADF00D, "both_setup");
    issue(0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h12345678, "both_enables");
    issue(0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, "both_unchanged");
  endtask

  // Reset during BUSY drops the pending write and its ready
  task automatic test_reset_mid_request();
    int seenReady;
    issue(0, 32'h20, 1'b0, 1'b1, 2'd2, 32'h11111111, "mid_setup");
    @(negedge clk);
    aAddr = 32'h20; aWen = 1'b1; aSize = 2'd2; aWData = 32'h22222222;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (aReady !== 1'b0 || aErr !== 1'b0 || aRData !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b err=%b rdata=%h, required 0/0/0",
               aReady, aErr, aRData);
    end
    aWen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seenReady = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (aReady === 1'b1) seenReady++;
    end
    checks++;
    if (seenReady != 0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_ready: got %0d ready cycles, required 0", seenReady);
    end
    issue(0, 32'h20, 1'b1, 1'b0, 2'd0, 32'h0, "mid_old_contents");
  endtask

  // LATENCY 1 with the read enable held: ready on every second cycle
  task automatic test_back_to_back();
    logic expRdy;
    issue(1, 32'h100, 1'b0, 1'b1, 2'd2, 32'hCAFEF00D, "b_write");
    issue(1, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, "b_below_base");
    issue(1, 32'h104, 1'b0, 1'b1, 2'd0, 32'h0000005A, "b_byte_write");
    @(negedge clk);
    bAddr = 32'h100; bRen = 1'b1; bWen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expRdy = (i % 2 == 0);
      if (i == 7) bRen = 1'b0;
      checks++;
      if (bReady !== expRdy) begin
        failures++;
        $display("[TB] FAIL b2b_ready[%0d]: got %b, required %b", i, bReady, expRdy);
      end
      if (expRdy) begin
        checks++;
        if (bRData !== 32'hCAFEF00D || bErr !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_rdata[%0d]: got %h err %b, required cafef00d err 0",
                   i, bRData, bErr);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    aAddr = '0; aRen = 0; aWen = 0; aSize = '0; aWData = '0;
    bAddr = '0; bRen = 0; bWen = 0; bSize = '0; bWData = '0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 256; w++)
        modelMem[s][w] = 32'hxxxxxxxx;
    test_reset();
    test_word_write_read();
    test_partial_writes();
    test_errors();
    test_both_enables();
    test_reset_mid_request();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
